// File: rtl/setpoint_ctrl_pkg.sv
// Shared types and default 50 MHz timing constants for the setpoint input controller.
package setpoint_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEBOUNCE  = 3'd1,
        ST_HOLD_WAIT = 3'd2,
        ST_REPEAT    = 3'd3,
        ST_RELEASE   = 3'd4
    } press_state_t;

    typedef enum logic {
        OWN_UP   = 1'b0,
        OWN_DOWN = 1'b1
    } owner_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
    localparam int unsigned DEF_CNT_W           = 25;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability counter; the stable output only
// moves after the synced input has held one new value for DEBOUNCE_CYCLES cycles.
module sync_debounce
    import setpoint_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             changed
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] stable_nxt;
    logic             changed_nxt;

    // Synchroniser, last-seen value, stability counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            cand    <= '0;
            cnt     <= '0;
            stable  <= '0;
            changed <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            cand    <= sync2;
            cnt     <= cnt_nxt;
            stable  <= stable_nxt;
            changed <= changed_nxt;
        end
    end

    // A new synced value restarts the run at 1; a value equal to stable clears it.
    always_comb begin
        cnt_eff     = (cnt >= TERM) ? cnt : cnt + CNT_W'(1);
        cnt_nxt     = cnt;
        stable_nxt  = stable;
        changed_nxt = 1'b0;
        if (sync2 != cand) begin
            cnt_eff = CNT_W'(1);
        end
        if (sync2 == stable) begin
            cnt_nxt = '0;
        end else if (cnt_eff >= TERM) begin
            stable_nxt  = sync2;
            changed_nxt = 1'b1;
            cnt_nxt     = '0;
        end else begin
            cnt_nxt = cnt_eff;
        end
    end

endmodule

// File: rtl/setpoint_input_ctrl.sv
// Button/switch front end: synchronises both buttons into a single press FSM with
// debounce and hold-to-repeat, and debounces the range switch onto sel.
module setpoint_input_ctrl
    import setpoint_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic [2:0] sw_raw,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [2:0] sel,
    output logic       sel_changed,
    output logic       holding
);

    localparam logic [CNT_W-1:0] DEB_T = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DLY_T = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PER_T = CNT_W'(REPEAT_PERIOD);

    logic         up_s1;
    logic         up_s2;
    logic         dn_s1;
    logic         dn_s2;
    press_state_t state;
    press_state_t state_nxt;
    owner_t       owner;
    owner_t       owner_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic         owner_lvl;
    logic         pulse_nxt;
    logic         up_nxt;
    logic         dn_nxt;
    logic         hold_nxt;

    // Range switch debouncer drives sel directly.
    sync_debounce #(
        .WIDTH           (3),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sw_debounce (
        .clk     (clk),
        .reset   (reset),
        .raw     (sw_raw),
        .stable  (sel),
        .changed (sel_changed)
    );

    // Button synchronisers, FSM state, shared press counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_s1      <= 1'b0;
            up_s2      <= 1'b0;
            dn_s1      <= 1'b0;
            dn_s2      <= 1'b0;
            state      <= ST_IDLE;
            owner      <= OWN_UP;
            cnt        <= '0;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            holding    <= 1'b0;
        end else begin
            up_s1      <= btn_up_raw;
            up_s2      <= up_s1;
            dn_s1      <= btn_down_raw;
            dn_s2      <= dn_s1;
            state      <= state_nxt;
            owner      <= owner_nxt;
            cnt        <= cnt_nxt;
            up_pulse   <= up_nxt;
            down_pulse <= dn_nxt;
            holding    <= hold_nxt;
        end
    end

    // Press FSM next state; counter always holds the number of qualifying cycles seen.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        owner_lvl = (owner == OWN_UP) ? up_s2 : dn_s2;
        cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (up_s2) begin
                    owner_nxt = OWN_UP;
                    state_nxt = ST_DEBOUNCE;
                    cnt_nxt   = CNT_W'(1);
                end else if (dn_s2) begin
                    owner_nxt = OWN_DOWN;
                    state_nxt = ST_DEBOUNCE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!owner_lvl) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DEB_T) begin
                    pulse_nxt = 1'b1;
                    state_nxt = ST_HOLD_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_HOLD_WAIT: begin
                if (!owner_lvl) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = CNT_W'(1);
                end else if (cnt_inc >= DLY_T) begin
                    pulse_nxt = 1'b1;
                    state_nxt = ST_REPEAT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_REPEAT: begin
                if (!owner_lvl) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = CNT_W'(1);
                end else if (cnt_inc >= PER_T) begin
                    pulse_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (owner_lvl) begin
                    state_nxt = ST_HOLD_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DEB_T) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        up_nxt   = pulse_nxt && (owner_nxt == OWN_UP);
        dn_nxt   = pulse_nxt && (owner_nxt == OWN_DOWN);
        hold_nxt = (state_nxt == ST_HOLD_WAIT) || (state_nxt == ST_REPEAT);
    end

endmodule
